// File: rtl/ariane_soc_pkg.sv
// Shared SoC definitions: slave-port ID width, AXI response encoding and
// the state enums of the default (unmapped) decode-error slave.
package ariane_soc;

    localparam int unsigned IdWidthSlave = 6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } decerr_w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } decerr_r_state_e;

endpackage

// File: rtl/soc_decerr_slave.sv
// Crossbar default slave: completes every unmapped AXI transaction with
// DECERR and logs a saturating error count plus the last offending address.
module soc_decerr_slave
    import ariane_soc::*;
#(
    parameter int unsigned          IdWidth   = ariane_soc::IdWidthSlave,
    parameter int unsigned          DataWidth = 64,
    parameter logic [DataWidth-1:0] ErrData   = 64'hBADC_AB1E_DEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [63:0]          aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [63:0]          ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [31:0]          err_cnt_o,
    output logic [63:0]          err_addr_o
);

    decerr_w_state_e     w_state_q, w_state_d;
    decerr_r_state_e     r_state_q, r_state_d;
    logic [IdWidth-1:0]  w_id_q, w_id_d;
    logic [IdWidth-1:0]  r_id_q, r_id_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [7:0]          r_cnt_q, r_cnt_d;
    logic [31:0]         err_cnt_q, err_cnt_d;
    logic [63:0]         err_addr_q, err_addr_d;
    logic [32:0]         err_sum;
    logic                aw_hs, ar_hs;

    // Every output decodes straight from flops, so no input-to-output path exists.
    assign aw_ready_o = (w_state_q == W_IDLE);
    assign w_ready_o  = (w_state_q == W_DATA);
    assign b_valid_o  = (w_state_q == W_RESP);
    assign b_id_o     = w_id_q;
    assign b_resp_o   = b_valid_o ? RESP_DECERR : RESP_OKAY;

    assign ar_ready_o = (r_state_q == R_IDLE);
    assign r_valid_o  = (r_state_q == R_DATA);
    assign r_id_o     = r_id_q;
    assign r_data_o   = r_valid_o ? ErrData : '0;
    assign r_resp_o   = r_valid_o ? RESP_DECERR : RESP_OKAY;
    assign r_last_o   = r_valid_o && (r_cnt_q == r_len_q);

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        unique case (w_state_q)
            W_IDLE: if (aw_hs) begin
                w_id_d    = aw_id_i;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_valid_i && w_last_i) w_state_d = W_RESP;
            W_RESP: if (b_ready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_id_d    = ar_id_i;
                r_len_d   = ar_len_i;
                r_cnt_d   = '0;
                r_state_d = R_DATA;
            end
            // The counter stops on the last beat, so len=255 never wraps it.
            R_DATA: if (r_ready_i) begin
                if (r_last_o) r_state_d = R_IDLE;
                else          r_cnt_d   = r_cnt_q + 8'd1;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + 33'(aw_hs) + 33'(ar_hs);
        err_cnt_d  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
        err_addr_d = err_addr_q;
        if (ar_hs)      err_addr_d = ar_addr_i;
        else if (aw_hs) err_addr_d = aw_addr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst_i) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            w_id_q     <= '0;
            r_id_q     <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            w_id_q     <= w_id_d;
            r_id_q     <= r_id_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Self-checking bench for soc_decerr_slave: vector table, directed corner
// sequences and a randomized phase against a transaction-level scoreboard.
module tb_soc_decerr_slave;

    localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_DEAD_BEEF;
    localparam logic [1:0]  DECERR   = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        aw_valid_i, aw_ready_o;
    logic [5:0]  aw_id_i;
    logic [63:0] aw_addr_i;
    logic        w_valid_i, w_ready_o, w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [5:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic [5:0]  ar_id_i;
    logic [63:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic        r_valid_o, r_ready_i;
    logic [5:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [31:0] err_cnt_o;
    logic [63:0] err_addr_o;

    soc_decerr_slave dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pending write IDs awaiting W-last, pending B IDs, pending R beats.
    typedef struct {
        logic [5:0] id;
        bit         last;
    } rbeat_t;

    logic [5:0]  awq[$];
    logic [5:0]  bq[$];
    rbeat_t      rq[$];
    logic [32:0] m_cnt;
    logic [63:0] m_addr;

    bit          last_aw_hs, last_w_hs, last_b_hs, last_ar_hs, last_r_hs;
    logic [5:0]  cap_b_id;
    logic [1:0]  cap_b_resp, cap_r_resp;
    logic        cap_r_last;
    logic [63:0] cap_r_data;

    bit          prev_r_stall, prev_b_stall;
    logic [5:0]  prev_r_id, prev_b_id;
    logic [63:0] prev_r_data;
    logic        prev_r_last;
    logic [1:0]  prev_r_resp, prev_b_resp;

    task automatic model_clear();
        awq.delete();
        bq.delete();
        rq.delete();
        m_cnt        = '0;
        m_addr       = '0;
        prev_r_stall = 1'b0;
        prev_b_stall = 1'b0;
    endtask

    task automatic check_outputs();
        check("aw_ready", 64'(aw_ready_o), 64'(awq.size() == 0 && bq.size() == 0));
        check("w_ready",  64'(w_ready_o),  64'(awq.size() != 0));
        check("b_valid",  64'(b_valid_o),  64'(bq.size() != 0));
        if (bq.size() != 0) begin
            check("b_id",   64'(b_id_o),   64'(bq[0]));
            check("b_resp", 64'(b_resp_o), 64'(DECERR));
        end
        check("ar_ready", 64'(ar_ready_o), 64'(rq.size() == 0));
        check("r_valid",  64'(r_valid_o),  64'(rq.size() != 0));
        if (rq.size() != 0) begin
            check("r_id",   64'(r_id_o),   64'(rq[0].id));
            check("r_data", r_data_o,      EXP_DATA);
            check("r_resp", 64'(r_resp_o), 64'(DECERR));
            check("r_last", 64'(r_last_o), 64'(rq[0].last));
        end
        check("err_cnt",  64'(err_cnt_o), 64'(m_cnt[31:0]));
        check("err_addr", err_addr_o,     m_addr);
        if (prev_r_stall) begin
            check("r_stable_id",   64'(r_id_o),   64'(prev_r_id));
            check("r_stable_data", r_data_o,      prev_r_data);
            check("r_stable_last", 64'(r_last_o), 64'(prev_r_last));
            check("r_stable_resp", 64'(r_resp_o), 64'(prev_r_resp));
        end
        if (prev_b_stall) begin
            check("b_stable_id",   64'(b_id_o),   64'(prev_b_id));
            check("b_stable_resp", 64'(b_resp_o), 64'(prev_b_resp));
        end
    endtask

    // Called at a falling edge with inputs already driven: predicts the
    // handshakes of the coming rising edge, then checks the next cycle.
    task automatic cycle();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [32:0] sum;
        aw_hs = aw_valid_i && aw_ready_o;
        w_hs  = w_valid_i  && w_ready_o;
        b_hs  = b_valid_o  && b_ready_i;
        ar_hs = ar_valid_i && ar_ready_o;
        r_hs  = r_valid_o  && r_ready_i;
        if (b_hs) begin
            cap_b_id   = b_id_o;
            cap_b_resp = b_resp_o;
        end
        if (r_hs) begin
            cap_r_last = r_last_o;
            cap_r_resp = r_resp_o;
            cap_r_data = r_data_o;
        end
        prev_r_stall = r_valid_o && !r_ready_i;
        prev_r_id    = r_id_o;
        prev_r_data  = r_data_o;
        prev_r_last  = r_last_o;
        prev_r_resp  = r_resp_o;
        prev_b_stall = b_valid_o && !b_ready_i;
        prev_b_id    = b_id_o;
        prev_b_resp  = b_resp_o;

        if (b_hs && bq.size() != 0) void'(bq.pop_front());
        if (w_hs && w_last_i && awq.size() != 0) bq.push_back(awq.pop_front());
        if (aw_hs) awq.push_back(aw_id_i);
        if (r_hs && rq.size() != 0) void'(rq.pop_front());
        if (ar_hs)
            for (int i = 0; i <= int'(ar_len_i); i++)
                rq.push_back('{id: ar_id_i, last: (i == int'(ar_len_i))});
        sum   = m_cnt + 33'(aw_hs) + 33'(ar_hs);
        m_cnt = (sum > 33'h0_FFFF_FFFF) ? 33'h0_FFFF_FFFF : sum;
        if (ar_hs)      m_addr = ar_addr_i;
        else if (aw_hs) m_addr = aw_addr_i;

        last_aw_hs = aw_hs;
        last_w_hs  = w_hs;
        last_b_hs  = b_hs;
        last_ar_hs = ar_hs;
        last_r_hs  = r_hs;
        @(negedge clk_i);
        check_outputs();
    endtask

    function automatic logic pick_ready(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return 1'((c % 2) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic drain(input string name);
        bit done = 1'b0;
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            w_valid_i = 1'b1;
            w_last_i  = 1'b1;
            b_ready_i = 1'b1;
            r_ready_i = 1'b1;
            cycle();
            done = (awq.size() == 0 && bq.size() == 0 && rq.size() == 0);
        end
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        check(name, 64'(done), 64'd1);
    endtask

    typedef struct {
        bit          is_wr;
        logic [5:0]  id;
        logic [63:0] addr;
        int          n;         // W beats for a write, AR len for a read
        int          rdy_mode;  // 0 always ready, 1 toggling 1010..., 2 random
        int          exp_beats; // B handshakes for a write, R beats for a read
        logic [1:0]  exp_resp;
        logic [31:0] exp_cnt;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        bit done  = 1'b0;
        int beats = 0;
        int last_at = 0;
        int w_left = v.n;
        string tag = $sformatf("vec%0d", idx);
        if (v.is_wr) begin
            aw_valid_i = 1'b1;
            aw_id_i    = v.id;
            aw_addr_i  = v.addr;
        end else begin
            ar_valid_i = 1'b1;
            ar_id_i    = v.id;
            ar_addr_i  = v.addr;
            ar_len_i   = 8'(v.n);
        end
        for (int c = 0; c < 600 && !done; c++) begin
            w_valid_i = v.is_wr && (w_left > 0);
            w_last_i  = (w_left == 1);
            b_ready_i = pick_ready(v.rdy_mode, c);
            r_ready_i = pick_ready(v.rdy_mode, c);
            cycle();
            if (last_aw_hs) aw_valid_i = 1'b0;
            if (last_ar_hs) ar_valid_i = 1'b0;
            if (last_w_hs) w_left--;
            if (last_b_hs) begin
                beats++;
                done = 1'b1;
                check({tag, "_b_id"},   64'(cap_b_id),   64'(v.id));
                check({tag, "_b_resp"}, 64'(cap_b_resp), 64'(v.exp_resp));
            end
            if (last_r_hs) begin
                beats++;
                if (cap_r_last) begin
                    if (last_at == 0) last_at = beats;
                    done = 1'b1;
                end
                if (beats == 1) begin
                    check({tag, "_r_resp"}, 64'(cap_r_resp), 64'(v.exp_resp));
                    check({tag, "_r_data"}, cap_r_data, EXP_DATA);
                end
            end
        end
        w_valid_i = 1'b0;
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        check({tag, "_done"},  64'(done),  64'd1);
        check({tag, "_beats"}, 64'(beats), 64'(v.exp_beats));
        if (!v.is_wr) check({tag, "_last_at"}, 64'(last_at), 64'(v.exp_beats));
        check({tag, "_cnt"},  64'(err_cnt_o), 64'(v.exp_cnt));
        check({tag, "_addr"}, err_addr_o,     v.exp_addr);
        check({tag, "_idle"}, 64'({aw_ready_o, ar_ready_o}), 64'd3);
    endtask

    initial begin
        int beats_after;
        int w_left;

        vecs[0] = '{1'b1, 6'd5,  64'h0000_0000_6000_0000, 3,   0, 1,   DECERR, 32'd1, 64'h0000_0000_6000_0000};
        vecs[1] = '{1'b0, 6'd9,  64'h0000_0000_6000_1000, 3,   1, 4,   DECERR, 32'd2, 64'h0000_0000_6000_1000};
        vecs[2] = '{1'b1, 6'h3F, 64'hFFFF_FFFF_FFFF_FFF8, 1,   2, 1,   DECERR, 32'd3, 64'hFFFF_FFFF_FFFF_FFF8};
        vecs[3] = '{1'b0, 6'd0,  64'h0000_0001_0000_0000, 0,   2, 1,   DECERR, 32'd4, 64'h0000_0001_0000_0000};
        vecs[4] = '{1'b0, 6'h2A, 64'h0000_0000_7FFF_FFC0, 255, 0, 256, DECERR, 32'd5, 64'h0000_0000_7FFF_FFC0};
        vecs[5] = '{1'b1, 6'd1,  64'h0000_0000_5000_0040, 8,   1, 1,   DECERR, 32'd6, 64'h0000_0000_5000_0040};

        rst_i      = 1'b1;
        aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0;
        w_valid_i  = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0;
        ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        r_ready_i  = 1'b0;
        model_clear();

        repeat (2) @(negedge clk_i);
        check("rst_aw_ready", 64'(aw_ready_o), 64'd1);
        check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        check("rst_w_ready",  64'(w_ready_o),  64'd0);
        check("rst_valids",   64'({b_valid_o, r_valid_o}), 64'd0);
        check("rst_r_last",   64'(r_last_o),   64'd0);
        check("rst_err_cnt",  64'(err_cnt_o),  64'd0);
        check("rst_err_addr", err_addr_o,      64'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous AW and AR: both counted, AR address recorded, each
        // response channel completes on its own schedule.
        aw_valid_i = 1'b1; aw_id_i = 6'd7; aw_addr_i = 64'h7000_0000;
        ar_valid_i = 1'b1; ar_id_i = 6'd3; ar_addr_i = 64'h6800_0000; ar_len_i = 8'd2;
        r_ready_i  = 1'b0; b_ready_i = 1'b0;
        cycle();
        check("dual_cnt",     64'(err_cnt_o), 64'd8);
        check("dual_addr",    err_addr_o,     64'h6800_0000);
        check("dual_r_lat",   64'(r_valid_o), 64'd1);
        aw_valid_i = 1'b0; ar_valid_i = 1'b0;
        w_valid_i  = 1'b1; w_last_i = 1'b0;
        cycle();
        w_last_i = 1'b1;
        cycle();
        w_valid_i = 1'b0;
        check("dual_b_lat",   64'(b_valid_o), 64'd1);
        drain("dual_drain");
        check("dual_cnt_end", 64'(err_cnt_o), 64'd8);

        // Saturation from a preloaded near-full count.
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_cnt_q;
        m_cnt = 33'h0_FFFF_FFFE;
        check("sat_preload", 64'(err_cnt_o), 64'h0_FFFF_FFFE);
        aw_valid_i = 1'b1; aw_id_i = 6'd12; aw_addr_i = 64'h7100_0000;
        ar_valid_i = 1'b1; ar_id_i = 6'd13; ar_addr_i = 64'h6900_0000; ar_len_i = 8'd0;
        cycle();
        check("sat_cnt", 64'(err_cnt_o), 64'h0_FFFF_FFFF);
        drain("sat_drain");
        ar_valid_i = 1'b1; ar_id_i = 6'd14; ar_addr_i = 64'h6A00_0000; ar_len_i = 8'd1;
        cycle();
        check("sat_hold", 64'(err_cnt_o), 64'h0_FFFF_FFFF);
        drain("sat_drain2");

        // Reset in the middle of a len=7 burst.
        ar_valid_i = 1'b1; ar_id_i = 6'd4; ar_addr_i = 64'h6000_2000; ar_len_i = 8'd7;
        r_ready_i  = 1'b0;
        cycle();
        ar_valid_i = 1'b0;
        r_ready_i  = 1'b1;
        cycle();
        check("mid_beat2_valid", 64'(r_valid_o), 64'd1);
        check("mid_beat2_last",  64'(r_last_o),  64'd0);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst_r_valid",  64'(r_valid_o),  64'd0);
        check("mid_rst_readies",  64'({aw_ready_o, ar_ready_o, w_ready_o}), 64'b110);
        check("mid_rst_b_valid",  64'(b_valid_o),  64'd0);
        check("mid_rst_r_last",   64'(r_last_o),   64'd0);
        check("mid_rst_err_cnt",  64'(err_cnt_o),  64'd0);
        check("mid_rst_err_addr", err_addr_o,      64'd0);
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
        beats_after = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (last_r_hs) beats_after++;
        end
        check("mid_no_beats", 64'(beats_after), 64'd0);

        // Randomized traffic on both channels at once.
        w_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!aw_valid_i && $urandom_range(0, 3) == 0) begin
                aw_valid_i = 1'b1;
                aw_id_i    = 6'($urandom);
                aw_addr_i  = {$urandom, $urandom};
            end
            if (w_left == 0) w_left = $urandom_range(1, 4);
            w_valid_i = 1'($urandom_range(0, 1));
            w_last_i  = (w_left == 1);
            if (!ar_valid_i && $urandom_range(0, 3) == 0) begin
                ar_valid_i = 1'b1;
                ar_id_i    = 6'($urandom);
                ar_addr_i  = {$urandom, $urandom};
                ar_len_i   = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            end
            b_ready_i = ($urandom_range(0, 2) != 0);
            r_ready_i = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_aw_hs) aw_valid_i = 1'b0;
            if (last_ar_hs) ar_valid_i = 1'b0;
            if (last_w_hs) w_left--;
        end
        for (int c = 0; c < 600 && (aw_valid_i || ar_valid_i); c++) begin
            w_valid_i = 1'b1;
            w_last_i  = 1'b1;
            b_ready_i = 1'b1;
            r_ready_i = 1'b1;
            cycle();
            if (last_aw_hs) aw_valid_i = 1'b0;
            if (last_ar_hs) ar_valid_i = 1'b0;
        end
        check("rand_addr_accepted", 64'({aw_valid_i, ar_valid_i}), 64'd0);
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_decerr_slave.md
SOC_DECERR_SLAVE -- requirements
Module: soc_decerr_slave

Interface
REQ-001 SHALL have parameter IdWidth, default ariane_soc::IdWidthSlave (6), AXI ID width of the crossbar slave port.
REQ-002 SHALL have parameter DataWidth, default 64, R data width.
REQ-003 SHALL have parameter ErrData, default 64'hBADC_AB1E_DEAD_BEEF, constant returned on every R beat.
REQ-004 SHALL have port clk_i  in  1  the single clock.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports aw_valid_i in 1 / aw_ready_o out 1 / aw_id_i in IdWidth / aw_addr_i in 64, for the write address channel.
REQ-007 SHALL have ports w_valid_i in 1 / w_ready_o out 1 / w_last_i in 1, for write data (payload ignored).
REQ-008 SHALL have ports b_valid_o out 1 / b_ready_i in 1 / b_id_o out IdWidth / b_resp_o out 2, for the write response.
REQ-009 SHALL have ports ar_valid_i in 1 / ar_ready_o out 1 / ar_id_i in IdWidth / ar_addr_i in 64 / ar_len_i in 8, for the read address channel.
REQ-010 SHALL have ports r_valid_o out 1 / r_ready_i in 1 / r_id_o out IdWidth / r_data_o out DataWidth / r_resp_o out 2 / r_last_o out 1, for read data.
REQ-011 SHALL have ports err_cnt_o out 32 (decode-error count) and err_addr_o out 64 (address of the last errored request).

Function
REQ-012 The block SHALL terminate every transaction the crossbar routes to it when no rule in the SoC address map matches, returning DECERR (2'b11) on all B and R responses.
REQ-013 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-014 In W_IDLE: aw_ready_o=1; on the AW handshake, capture aw_id_i and go to W_DATA.
REQ-015 In W_DATA: w_ready_o=1; each beat is discarded; on a beat with w_last_i=1, go to W_RESP.
REQ-016 In W_RESP: b_valid_o=1, b_id_o=captured ID, b_resp_o=2'b11; on b_ready_i, go to W_IDLE.
REQ-017 w_ready_o SHALL be 0 outside W_DATA; W beats arriving before AW are stalled, not dropped.
REQ-018 The read FSM SHALL have states R_IDLE and R_DATA.
REQ-019 In R_IDLE: ar_ready_o=1; on the AR handshake, capture ar_id_i, load the 8-bit length from ar_len_i, clear the beat counter and go to R_DATA.
REQ-020 In R_DATA: r_valid_o=1, r_data_o=ErrData, r_resp_o=2'b11, r_id_o=captured ID, r_last_o=(beat counter==length).
REQ-021 Each R handshake SHALL increment the beat counter; a handshake with r_last_o=1 returns the FSM to R_IDLE.
REQ-022 ar_len_i=255 SHALL produce exactly 256 beats with no counter overflow.
REQ-023 r_valid_o/b_valid_o and all payloads SHALL be held stable until accepted.
REQ-024 Read and write FSMs SHALL be fully independent, with no ordering between them.
REQ-025 err_cnt_o SHALL increment by 1 per accepted AW or AR, and by 2 when both are accepted in the same cycle.
REQ-026 err_cnt_o SHALL saturate at 32'hFFFF_FFFF.
REQ-027 err_addr_o SHALL take the accepted address; on a simultaneous AW+AR, ar_addr_i wins.
REQ-028 Outputs SHALL be registered; first B or R valid appears 1 cycle after the AW-last-W or AR handshake respectively, with no other latency added.

Reset
REQ-029 rst_i SHALL asynchronously force the FSMs to W_IDLE and R_IDLE, and clear the counters, captured IDs and err_addr_o to 0.
REQ-030 Resulting reset output values: aw_ready_o=1, ar_ready_o=1, all valids 0, w_ready_o=0, r_last_o=0, err_cnt_o=0.
REQ-031 A reset mid-burst SHALL abandon the transaction silently: no B/R is issued after deassertion.

Structure
REQ-032 The DECERR encoding and the FSM state enums SHALL live in ariane_soc (shared package); ErrData stays a module parameter.
REQ-033 The block SHALL be a single module with no sub-modules; it instantiates as the crossbar default (unmapped) slave.

Verification
REQ-034 AW id=5 addr=0x6000_0000, 3 W beats, the last with w_last=1, b_ready=1 -> one B with id=5, resp=2'b11; err_cnt_o=1; err_addr_o=0x6000_0000.
REQ-035 AR id=9 len=3, r_ready toggling 1010... -> exactly 4 R beats, each with data 0xBADCAB1EDEADBEEF and resp=2'b11; r_last only on beat 4; payload stable while stalled.
REQ-036 AW addr=0x7000_0000 and AR addr=0x6800_0000 in the same cycle -> err_cnt_o increments by 2; err_addr_o=0x6800_0000; both responses complete independently.
REQ-037 AR len=255 -> 256 beats, r_last on beat 256, FSM back to R_IDLE (ar_ready_o=1).
REQ-038 Counter forced to 0xFFFF_FFFE, then AW+AR in the same cycle -> err_cnt_o=0xFFFF_FFFF and it holds there.
REQ-039 rst_i asserted during beat 2 of a len=7 read -> outputs reach reset values immediately; no R beat is issued after release.
